// File: rtl/cdb_requester.sv
// cdb_requester: requester-side agent for a fixed-priority CDB arbiter, one per functional unit.
// Completed results (ROB tag + data) are queued in a small circular FIFO. request_OUT is high
// while the FIFO holds anything. On grant the head entry is driven onto the CDB for that cycle
// and popped at the edge.
//
// Optional feature: define CDB_REQ_FLUSH_EN to add flush_IN, which empties the FIFO at the edge.
//
// Ports:
//   clk_IN         clock, all state updates on rising edge
//   reset_IN       synchronous active-high reset
//   flush_IN       pipeline flush (only with CDB_REQ_FLUSH_EN)
//   fu_valid_IN    FU presents a result this cycle
//   fu_tag_IN      ROB tag of the result
//   fu_data_IN     result value
//   fu_ready_OUT   FIFO can accept a result this cycle
//   request_OUT    request into the arbiter
//   grant_IN       grant from the arbiter, same cycle
//   cdb_valid_OUT  this unit owns the CDB this cycle
//   cdb_tag_OUT    broadcast tag (0 when not valid)
//   cdb_data_OUT   broadcast data (0 when not valid)
module cdb_requester #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_IN,
  input  logic              reset_IN,
`ifdef CDB_REQ_FLUSH_EN
  input  logic              flush_IN,
`endif
  input  logic              fu_valid_IN,
  input  logic [TAG_W-1:0]  fu_tag_IN,
  input  logic [DATA_W-1:0] fu_data_IN,
  output logic              fu_ready_OUT,
  output logic              request_OUT,
  input  logic              grant_IN,
  output logic              cdb_valid_OUT,
  output logic [TAG_W-1:0]  cdb_tag_OUT,
  output logic [DATA_W-1:0] cdb_data_OUT
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic clear;

`ifdef CDB_REQ_FLUSH_EN
  assign clear = reset_IN | flush_IN;
`else
  assign clear = reset_IN;
`endif

  // Both flags come from registered count only, so request never loops back through the arbiter.
  assign fu_ready_OUT = (count_q != CntW'(DEPTH));
  assign request_OUT  = (count_q != '0);

  assign push = fu_valid_IN & fu_ready_OUT;
  // A reset cycle discards everything, including a would-be broadcast; a flush cycle does not.
  assign pop  = grant_IN & request_OUT & ~reset_IN;

  assign cdb_valid_OUT = pop;
  assign cdb_tag_OUT   = pop ? tag_mem_q[rd_ptr_q]  : '0;
  assign cdb_data_OUT  = pop ? data_mem_q[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_IN) begin
    if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk_IN) begin
    if (push) begin
      tag_mem_q[wr_ptr_q]  <= fu_tag_IN;
      data_mem_q[wr_ptr_q] <= fu_data_IN;
    end
  end

endmodule

// File: tb/tb_cdb_requester.sv
module tb_cdb_requester;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fu_valid = 1'b0;
  logic [5:0]  fu_tag = '0;
  logic [31:0] fu_data = '0;
  logic        fu_ready;
  logic        request;
  logic        grant = 1'b0;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
`ifdef CDB_REQ_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cdb_requester #(
    .DEPTH  (Depth),
    .TAG_W  (6),
    .DATA_W (32)
  ) dut (
    .clk_IN        (clk),
    .reset_IN      (reset),
`ifdef CDB_REQ_FLUSH_EN
    .flush_IN      (flush),
`endif
    .fu_valid_IN   (fu_valid),
    .fu_tag_IN     (fu_tag),
    .fu_data_IN    (fu_data),
    .fu_ready_OUT  (fu_ready),
    .request_OUT   (request),
    .grant_IN      (grant),
    .cdb_valid_OUT (cdb_valid),
    .cdb_tag_OUT   (cdb_tag),
    .cdb_data_OUT  (cdb_data)
  );

  // Inputs change 1 time unit after the rising edge; outputs are looked at mid-cycle.
  task automatic drive(input logic v, input logic [5:0] t, input logic [31:0] d, input logic g);
    fu_valid = v;
    fu_tag   = t;
    fu_data  = d;
    grant    = g;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if ({fu_ready, request, cdb_valid, cdb_tag, cdb_data} !== {3'b100, 6'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: rdy/req/vld=%b%b%b tag=%0d data=%h, want 100 tag 0 data 0",
               fu_ready, request, cdb_valid, cdb_tag, cdb_data);
    end
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 6'd5, 32'hDEADBEEF, 1'b0);
    tests_run++;
    if (request !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_no_bypass: request=%b want 0", request);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if ({request, cdb_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_request: req/vld=%b%b want 10", request, cdb_valid);
    end
    tick();
    drive(1'b0, '0, '0, 1'b1);
    tests_run++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 6'd5, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL single_broadcast: vld=%b tag=%0d data=%h want 1 5 deadbeef",
               cdb_valid, cdb_tag, cdb_data);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if ({request, fu_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_after: req/rdy=%b%b want 01", request, fu_ready);
    end
    tick();
  endtask

  task automatic test_fill_drop();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(10 + i), 32'(i) * 32'h11111111, 1'b0);
      tests_run++;
      if (fu_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL fill_ready[%0d]: fu_ready=%b want 1", i, fu_ready);
      end
      tick();
    end
    drive(1'b1, 6'd63, 32'hFFFFFFFF, 1'b0);
    tests_run++;
    if ({fu_ready, request} !== 2'b01) begin
      tests_failed++;
      $display("FAIL fill_full: rdy/req=%b%b want 01", fu_ready, request);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      tests_run++;
      if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 6'(10 + i), 32'(i) * 32'h11111111}) begin
        tests_failed++;
        $display("FAIL fill_drain[%0d]: vld=%b tag=%0d data=%h want 1 %0d %h", i, cdb_valid,
                 cdb_tag, cdb_data, 10 + i, 32'(i) * 32'h11111111);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    tests_run++;
    if ({request, cdb_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL fill_dropped_absent: req/vld=%b%b want 00", request, cdb_valid);
    end
    tick();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(20 + i), 32'(100 + i), 1'b0);
      tick();
    end
    drive(1'b1, 6'd30, 32'd300, 1'b1);
    tests_run++;
    if ({fu_ready, cdb_valid, cdb_tag} !== {2'b01, 6'd20}) begin
      tests_failed++;
      $display("FAIL fullpp_cycle: rdy/vld=%b%b tag=%0d want 01 tag 20",
               fu_ready, cdb_valid, cdb_tag);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if ({fu_ready, request} !== 2'b11) begin
      tests_failed++;
      $display("FAIL fullpp_next: rdy/req=%b%b want 11", fu_ready, request);
    end
    tick();
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      tests_run++;
      if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 6'(20 + i), 32'(100 + i)}) begin
        tests_failed++;
        $display("FAIL fullpp_drain[%0d]: vld=%b tag=%0d data=%0d want 1 %0d %0d", i,
                 cdb_valid, cdb_tag, cdb_data, 20 + i, 100 + i);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if (request !== 1'b0) begin
      tests_failed++;
      $display("FAIL fullpp_count3: request=%b want 0 after three pops", request);
    end
    tick();
  endtask

  task automatic test_grant_toggle();
    drive(1'b1, 6'd40, 32'd400, 1'b0);
    tick();
    drive(1'b1, 6'd41, 32'd401, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2) == 1;
      drive(1'b0, '0, '0, g);
      tests_run++;
      if ({request, cdb_valid} !== {1'b1, g} || (g && cdb_tag !== 6'(40 + i / 2))) begin
        tests_failed++;
        $display("FAIL toggle[%0d]: req/vld=%b%b tag=%0d want 1%b tag %0d", i, request,
                 cdb_valid, cdb_tag, g, 40 + i / 2);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if (request !== 1'b0) begin
      tests_failed++;
      $display("FAIL toggle_end: request=%b want 0", request);
    end
    tick();
  endtask

  task automatic test_empty_and_reset();
    drive(1'b0, '0, '0, 1'b1);
    tests_run++;
    if ({cdb_valid, cdb_tag, cdb_data} !== 39'd0) begin
      tests_failed++;
      $display("FAIL empty_grant: vld=%b tag=%0d data=%h want 0 0 0",
               cdb_valid, cdb_tag, cdb_data);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if ({request, fu_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL empty_after: req/rdy=%b%b want 01", request, fu_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(50 + i), 32'(500 + i), 1'b0);
      tick();
    end
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    tests_run++;
    if (cdb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_broadcast: cdb_valid=%b want 0", cdb_valid);
    end
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    tests_run++;
    if ({request, fu_ready, cdb_valid} !== 3'b010) begin
      tests_failed++;
      $display("FAIL reset_midop: req/rdy/vld=%b%b%b want 010", request, fu_ready, cdb_valid);
    end
    tick();
  endtask

  task automatic test_random();
    logic [37:0] model_q[$];
    logic        exp_ready, exp_req, exp_pop, v, g;
    logic [5:0]  t, exp_tag;
    logic [31:0] d, exp_data;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v = $urandom_range(0, 99) < 60;
      g = $urandom_range(0, 99) < 45;
      t = 6'($urandom);
      d = $urandom;
      exp_ready = model_q.size() < Depth;
      exp_req   = model_q.size() > 0;
      exp_pop   = g && exp_req;
      exp_tag   = exp_pop ? model_q[0][37:32] : 6'd0;
      exp_data  = exp_pop ? model_q[0][31:0] : 32'd0;
      drive(v, t, d, g);
      tests_run++;
      if ({fu_ready, request, cdb_valid, cdb_tag, cdb_data} !==
          {exp_ready, exp_req, exp_pop, exp_tag, exp_data}) begin
        tests_failed++;
        $display("FAIL random[%0d]: rdy/req/vld=%b%b%b tag=%0d data=%h want %b%b%b tag=%0d data=%h",
                 c, fu_ready, request, cdb_valid, cdb_tag, cdb_data,
                 exp_ready, exp_req, exp_pop, exp_tag, exp_data);
      end
      if (exp_pop) void'(model_q.pop_front());
      if (v && exp_ready) model_q.push_back({t, d});
      tick();
    end
    // Leave the DUT empty for the following tests.
    do_reset();
  endtask

`ifdef CDB_REQ_FLUSH_EN
  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(60 + i), 32'(600 + i), 1'b0);
      tick();
    end
    flush = 1'b1;
    drive(1'b1, 6'd63, 32'd777, 1'b1);
    tests_run++;
    if ({request, cdb_valid, cdb_tag} !== {2'b11, 6'd60}) begin
      tests_failed++;
      $display("FAIL flush_cycle: req/vld=%b%b tag=%0d want 11 tag 60", request, cdb_valid,
               cdb_tag);
    end
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    tests_run++;
    if ({request, fu_ready, cdb_valid} !== 3'b010) begin
      tests_failed++;
      $display("FAIL flush_after: req/rdy/vld=%b%b%b want 010", request, fu_ready, cdb_valid);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_drop();
    test_full_push_pop();
    test_grant_toggle();
    test_empty_and_reset();
    test_random();
`ifdef CDB_REQ_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
